// File: rtl/sdram_arbiter_if.sv
// Bus between the SDRAM arbiter, its requesters (cache, flash DMA) and the controller command port.
// The arbiter uses the slave modport; requesters and the controller form the master side.
interface sdram_arbiter_if #(
    parameter int NumReq          = 2,
    parameter int AddressBitWidth = 21
);
    logic                               sdrc_init_done;
    logic [NumReq-1:0]                  req;
    logic [NumReq*3-1:0]                req_cmd;
    logic [NumReq*AddressBitWidth-1:0]  req_addr;
    logic [NumReq*8-1:0]                req_len;
    logic [NumReq*4-1:0]                req_dqm;
    logic [NumReq*32-1:0]               req_wdata;
    logic [NumReq-1:0]                  grant;
    logic                               wr_next;
    logic                               rd_valid;
    logic [NumReq-1:0]                  done;
    logic                               sdrc_cmd_en;
    logic [2:0]                         sdrc_cmd;
    logic [AddressBitWidth-1:0]         sdrc_addr;
    logic [7:0]                         sdrc_len;
    logic [3:0]                         sdrc_dqm;
    logic [31:0]                        sdrc_wdata;
    logic                               sdrc_cmd_ack;

    modport slave (
        input  sdrc_init_done, req, req_cmd, req_addr, req_len, req_dqm, req_wdata, sdrc_cmd_ack,
        output grant, wr_next, rd_valid, done,
        output sdrc_cmd_en, sdrc_cmd, sdrc_addr, sdrc_len, sdrc_dqm, sdrc_wdata
    );

    modport master (
        output sdrc_init_done, req, req_cmd, req_addr, req_len, req_dqm, req_wdata, sdrc_cmd_ack,
        input  grant, wr_next, rd_valid, done,
        input  sdrc_cmd_en, sdrc_cmd, sdrc_addr, sdrc_len, sdrc_dqm, sdrc_wdata
    );
endinterface

// File: rtl/sdram_arbiter.sv
// Round-robin owner of the SDRAM controller command port with periodic auto-refresh.
// One transaction at a time: IDLE -> ISSUE -> WAIT_ACK -> DATA -> RECOVER -> IDLE.
module sdram_arbiter #(
    parameter int         NumReq                = 2,
    parameter int         AddressBitWidth       = 21,
    parameter int         RefreshIntervalCycles = 405,
    parameter int         ReadLatencyCycles     = 4,
    parameter int         RecoverCycles         = 2,
    parameter logic [2:0] CmdWrite              = 3'b100,
    parameter logic [2:0] CmdRead               = 3'b101,
    parameter logic [2:0] CmdRefresh            = 3'b001
) (
    input logic            clk,
    input logic            rst,
    sdram_arbiter_if.slave bus
);

    localparam int IdxW = $clog2(NumReq);
    localparam int RefW = $clog2(RefreshIntervalCycles);
    localparam int LatW = (ReadLatencyCycles > 1) ? $clog2(ReadLatencyCycles) : 1;
    localparam int RecW = (RecoverCycles > 1) ? $clog2(RecoverCycles) : 1;

    typedef enum logic [2:0] {Idle, Issue, WaitAck, Data, Recover} state_t;

    state_t                     state_q;
    logic [IdxW-1:0]            rr_q;
    logic [IdxW-1:0]            owner_q;
    logic [RefW-1:0]            refCnt_q;
    logic                       refPending_q;
    logic                       isRefresh_q;
    logic                       isWrite_q;
    logic [8:0]                 beatCnt_q;
    logic [LatW-1:0]            latCnt_q;
    logic [RecW-1:0]            recCnt_q;
    logic [NumReq-1:0]          grant_q;
    logic [NumReq-1:0]          done_q;
    logic                       cmdEn_q;
    logic [2:0]                 cmd_q;
    logic [AddressBitWidth-1:0] addr_q;
    logic [7:0]                 len_q;
    logic [3:0]                 dqm_q;

    logic [IdxW-1:0]            winner_d;
    logic                       winnerValid_d;
    logic [IdxW-1:0]            nextRr_d;
    logic [2:0]                 winCmd_d;
    logic                       refDue_d;
    logic [NumReq-1:0]          recDone_d;

    // Descending scan so the requester closest to rr_q (upward, modulo NumReq) is assigned last and wins.
    always_comb begin
        winnerValid_d = 1'b0;
        winner_d      = '0;
        for (int k = NumReq - 1; k >= 0; k--) begin
            if (bus.req[(int'(rr_q) + k) % NumReq]) begin
                winnerValid_d = 1'b1;
                winner_d      = IdxW'((int'(rr_q) + k) % NumReq);
            end
        end
    end

    assign nextRr_d  = (winner_d == IdxW'(NumReq - 1)) ? '0 : winner_d + 1'b1;
    assign winCmd_d  = bus.req_cmd[int'(winner_d)*3 +: 3];
    assign refDue_d  = bus.sdrc_init_done && (refCnt_q == RefW'(RefreshIntervalCycles - 1));
    assign recDone_d = (RecoverCycles == 1 && !isRefresh_q) ? grant_q : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= Idle;
            rr_q         <= '0;
            owner_q      <= '0;
            refCnt_q     <= '0;
            refPending_q <= 1'b0;
            isRefresh_q  <= 1'b0;
            isWrite_q    <= 1'b0;
            beatCnt_q    <= '0;
            latCnt_q     <= '0;
            recCnt_q     <= '0;
            grant_q      <= '0;
            done_q       <= '0;
            cmdEn_q      <= 1'b0;
            cmd_q        <= '0;
            addr_q       <= '0;
            len_q        <= '0;
            dqm_q        <= '0;
        end else begin
            done_q <= '0;
            if (bus.sdrc_init_done) begin
                refCnt_q <= refDue_d ? '0 : refCnt_q + 1'b1;
            end

            case (state_q)
                Idle: begin
                    if (bus.sdrc_init_done && refPending_q) begin
                        state_q     <= Issue;
                        cmdEn_q     <= 1'b1;
                        cmd_q       <= CmdRefresh;
                        addr_q      <= '0;
                        len_q       <= '0;
                        dqm_q       <= '0;
                        isRefresh_q <= 1'b1;
                        isWrite_q   <= 1'b0;
                        grant_q     <= '0;
                    end else if (bus.sdrc_init_done && winnerValid_d) begin
                        state_q     <= Issue;
                        cmdEn_q     <= 1'b1;
                        cmd_q       <= (winCmd_d == CmdRead) ? CmdRead : CmdWrite;
                        addr_q      <= bus.req_addr[int'(winner_d)*AddressBitWidth +: AddressBitWidth];
                        len_q       <= bus.req_len[int'(winner_d)*8 +: 8];
                        dqm_q       <= bus.req_dqm[int'(winner_d)*4 +: 4];
                        isRefresh_q <= 1'b0;
                        isWrite_q   <= (winCmd_d != CmdRead);
                        owner_q     <= winner_d;
                        grant_q     <= NumReq'(1) << winner_d;
                        rr_q        <= nextRr_d;
                    end
                end
                Issue: begin
                    cmdEn_q <= 1'b0;
                    state_q <= WaitAck;
                end
                WaitAck: begin
                    if (bus.sdrc_cmd_ack) begin
                        latCnt_q <= LatW'(ReadLatencyCycles - 1);
                        if (isRefresh_q || (isWrite_q && len_q == 8'd0)) begin
                            if (isRefresh_q) begin
                                refPending_q <= 1'b0;
                            end
                            state_q  <= Recover;
                            recCnt_q <= RecW'(RecoverCycles - 1);
                            done_q   <= recDone_d;
                        end else begin
                            state_q   <= Data;
                            beatCnt_q <= isWrite_q ? {1'b0, len_q} : {1'b0, len_q} + 9'd1;
                        end
                    end
                end
                Data: begin
                    // The write ack cycle already carried the first beat, so writes count len and reads len+1.
                    if (isWrite_q || latCnt_q == '0) begin
                        beatCnt_q <= beatCnt_q - 9'd1;
                        if (beatCnt_q == 9'd1) begin
                            state_q  <= Recover;
                            recCnt_q <= RecW'(RecoverCycles - 1);
                            done_q   <= recDone_d;
                        end
                    end else begin
                        latCnt_q <= latCnt_q - 1'b1;
                    end
                end
                Recover: begin
                    if (recCnt_q == '0) begin
                        state_q <= Idle;
                        grant_q <= '0;
                    end else begin
                        recCnt_q <= recCnt_q - 1'b1;
                        if (recCnt_q == RecW'(1) && !isRefresh_q) begin
                            done_q <= grant_q;
                        end
                    end
                end
                default: state_q <= Idle;
            endcase

            if (refDue_d) begin
                refPending_q <= 1'b1;
            end
        end
    end

    assign bus.grant       = grant_q;
    assign bus.done        = done_q;
    assign bus.sdrc_cmd_en = cmdEn_q;
    assign bus.sdrc_cmd    = cmd_q;
    assign bus.sdrc_addr   = addr_q;
    assign bus.sdrc_len    = len_q;
    assign bus.sdrc_dqm    = dqm_q;
    assign bus.wr_next     = isWrite_q && ((state_q == WaitAck && bus.sdrc_cmd_ack) || state_q == Data);
    assign bus.rd_valid    = !isWrite_q && state_q == Data && latCnt_q == '0;
    assign bus.sdrc_wdata  = (|grant_q) ? bus.req_wdata[int'(owner_q)*32 +: 32] : 32'd0;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: a small controller model acks each command two cycles later,
// negedge monitors record beats, dones and command issues, and one initial block checks them.
module tb_sdram_arbiter;

    localparam int         NumReq     = 2;
    localparam int         Aw         = 21;
    localparam logic [2:0] CmdWrite   = 3'b100;
    localparam logic [2:0] CmdRead    = 3'b101;
    localparam logic [2:0] CmdRefresh = 3'b001;

    logic clk = 1'b0;
    logic rst = 1'b1;

    sdram_arbiter_if #(.NumReq(NumReq), .AddressBitWidth(Aw)) bus ();

    sdram_arbiter #(.NumReq(NumReq), .AddressBitWidth(Aw)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors     = 0;
    int miscompares = 0;
    int ackDelay    = 2;

    int wrCnt = 0, rdCnt = 0, done0Cnt = 0, done1Cnt = 0, cmdEnCnt = 0, refCnt = 0;
    int multiGrant = 0, grantNz = 0, nonRefCmdCyc = 0, ackCyc = 0;
    int wrStartCyc = 0, rdStartCyc = 0, doneCyc = 0, seqIdx = 0;
    int refCyc [8];
    logic [1:0]    grantSeq [16];
    logic          prevWr = 1'b0, prevRd = 1'b0;
    logic [2:0]    capCmd = '0;
    logic [Aw-1:0] capAddr = '0;
    logic [7:0]    capLen = '0;
    logic [3:0]    capDqm = '0;
    logic [31:0]   capWdata = '0;
    logic [1:0]    capGrant = '0;

    // Observation point is the falling edge, half a cycle away from the DUT's active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.wr_next) begin
                wrCnt++;
                if (!prevWr) wrStartCyc = cyc;
            end
            if (bus.rd_valid) begin
                rdCnt++;
                if (!prevRd) rdStartCyc = cyc;
            end
            prevWr = bus.wr_next;
            prevRd = bus.rd_valid;
            if (bus.sdrc_cmd_ack) ackCyc = cyc;
            if (bus.done[0]) begin done0Cnt++; doneCyc = cyc; end
            if (bus.done[1]) begin done1Cnt++; doneCyc = cyc; end
            if ($countones(bus.grant) > 1) multiGrant++;
            if (bus.grant != '0) grantNz++;
            if (bus.sdrc_cmd_en) begin
                cmdEnCnt++;
                capCmd   = bus.sdrc_cmd;
                capAddr  = bus.sdrc_addr;
                capLen   = bus.sdrc_len;
                capDqm   = bus.sdrc_dqm;
                capWdata = bus.sdrc_wdata;
                capGrant = bus.grant;
                if (bus.sdrc_cmd == CmdRefresh) begin
                    if (refCnt < 8) refCyc[refCnt] = cyc;
                    refCnt++;
                end else begin
                    nonRefCmdCyc = cyc;
                    if (seqIdx < 16) grantSeq[seqIdx] = bus.grant;
                    seqIdx++;
                end
            end
        end else begin
            prevWr = 1'b0;
            prevRd = 1'b0;
        end
    end

    // Controller model: a command seen in cycle c is acknowledged for one cycle in cycle c+ackDelay.
    initial begin
        bus.sdrc_cmd_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.sdrc_cmd_en && !rst) begin
                repeat (ackDelay) @(posedge clk);
                #1 bus.sdrc_cmd_ack = 1'b1;
                @(posedge clk);
                #1 bus.sdrc_cmd_ack = 1'b0;
            end
        end
    end

    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic resetDut(input logic initDone, output int relCyc);
        rst                = 1'b1;
        bus.req            = '0;
        bus.sdrc_init_done = initDone;
        repeat (3) tick();
        rst    = 1'b0;
        relCyc = cyc;
    endtask

    task automatic applyStimulus(input int idx, input logic [2:0] cmd, input logic [Aw-1:0] addr,
                                 input logic [7:0] len, input logic [3:0] dqm, input logic [31:0] wdata);
        bus.req_cmd[idx*3 +: 3]    = cmd;
        bus.req_addr[idx*Aw +: Aw] = addr;
        bus.req_len[idx*8 +: 8]    = len;
        bus.req_dqm[idx*4 +: 4]    = dqm;
        bus.req_wdata[idx*32 +: 32] = wdata;
        bus.req[idx]               = 1'b1;
    endtask

    task automatic waitDone(input int idx, input int budget, input string tag);
        int base;
        int n;
        base = (idx == 0) ? done0Cnt : done1Cnt;
        n    = 0;
        while (((idx == 0) ? done0Cnt : done1Cnt) == base && n < budget) begin
            tick();
            n++;
        end
        bus.req[idx] = 1'b0;
        checkOutput(tag, ((idx == 0) ? done0Cnt : done1Cnt) - base, 1);
    endtask

    initial begin
        int relCyc, n, b, bWr, bRd, bCmd, bD0, bD1, bSeq, bRef, bNz, bMulti;

        bus.req            = '0;
        bus.req_cmd        = '0;
        bus.req_addr       = '0;
        bus.req_len        = '0;
        bus.req_dqm        = '0;
        bus.req_wdata      = '0;
        bus.sdrc_init_done = 1'b1;

        // Reset values
        repeat (2) tick();
        checkOutput("rstGrant",  bus.grant, 0);
        checkOutput("rstCmdEn",  bus.sdrc_cmd_en, 0);
        checkOutput("rstDone",   bus.done, 0);
        checkOutput("rstWrNext", bus.wr_next, 0);
        checkOutput("rstRdVal",  bus.rd_valid, 0);
        checkOutput("rstCmd",    bus.sdrc_cmd, 0);
        rst = 1'b0;

        // Write burst from requester 0, len 3
        bWr = wrCnt; bCmd = cmdEnCnt; bD1 = done1Cnt; bMulti = multiGrant;
        applyStimulus(0, CmdWrite, 21'h00100, 8'd3, 4'h0, 32'hA5A5_0001);
        waitDone(0, 60, "wrDone");
        checkOutput("wrCmdEnCount", cmdEnCnt - bCmd, 1);
        checkOutput("wrCmd",        capCmd, CmdWrite);
        checkOutput("wrAddr",       capAddr, 21'h00100);
        checkOutput("wrLen",        capLen, 3);
        checkOutput("wrWdataMux",   capWdata, 32'hA5A5_0001);
        checkOutput("wrGrant",      capGrant, 2'b01);
        checkOutput("wrBeats",      wrCnt - bWr, 4);
        checkOutput("wrStartAtAck", wrStartCyc - ackCyc, 0);
        checkOutput("wrDoneDelay",  doneCyc - ackCyc, 5);
        checkOutput("wrNoDone1",    done1Cnt - bD1, 0);
        repeat (3) tick();
        checkOutput("wrGrantRel",   bus.grant, 0);
        checkOutput("wrOneGrant",   multiGrant - bMulti, 0);

        // Read burst from requester 1, len 0
        bWr = wrCnt; bRd = rdCnt;
        applyStimulus(1, CmdRead, 21'h1FFFFF, 8'd0, 4'hF, 32'h0);
        waitDone(1, 60, "rdDone");
        checkOutput("rdCmd",       capCmd, CmdRead);
        checkOutput("rdAddr",      capAddr, 21'h1FFFFF);
        checkOutput("rdDqm",       capDqm, 4'hF);
        checkOutput("rdGrant",     capGrant, 2'b10);
        checkOutput("rdBeats",     rdCnt - bRd, 1);
        checkOutput("rdLatency",   rdStartCyc - ackCyc, 4);
        checkOutput("rdDoneDelay", doneCyc - ackCyc, 6);
        checkOutput("rdNoWrNext",  wrCnt - bWr, 0);

        // Both requesters held: strict alternation starting at requester 0
        resetDut(1'b1, relCyc);
        bD0 = done0Cnt; bD1 = done1Cnt; bSeq = seqIdx; bWr = wrCnt; bMulti = multiGrant;
        applyStimulus(0, CmdWrite, 21'h00010, 8'd1, 4'h0, 32'h1111_1111);
        applyStimulus(1, CmdWrite, 21'h00020, 8'd1, 4'h0, 32'h2222_2222);
        n = 0;
        while ((done0Cnt + done1Cnt) - (bD0 + bD1) < 4 && n < 300) begin
            tick();
            n++;
        end
        bus.req = '0;
        checkOutput("rrBursts", (done0Cnt + done1Cnt) - (bD0 + bD1), 4);
        for (int k = 0; k < 4; k++) begin
            if (bSeq + k < 16) begin
                checkOutput($sformatf("rrGrant%0d", k), grantSeq[bSeq + k], (k % 2 == 0) ? 1 : 2);
            end
        end
        checkOutput("rrDone0",     done0Cnt - bD0, 2);
        checkOutput("rrDone1",     done1Cnt - bD1, 2);
        checkOutput("rrBeats",     wrCnt - bWr, 8);
        checkOutput("rrOneGrant",  multiGrant - bMulti, 0);

        // Idle refresh pacing, then refresh colliding with a request
        resetDut(1'b1, relCyc);
        bRef = refCnt; bNz = grantNz; bWr = wrCnt;
        n = 0;
        while (refCnt - bRef < 3 && n < 1300) begin
            tick();
            n++;
        end
        checkOutput("refCount3", refCnt - bRef, 3);
        if (refCnt - bRef >= 3 && bRef + 3 < 8) begin
            checkOutput("refFirst",  refCyc[bRef] - relCyc, 406);
            checkOutput("refGap1",   refCyc[bRef + 1] - refCyc[bRef], 405);
            checkOutput("refGap2",   refCyc[bRef + 2] - refCyc[bRef + 1], 405);
        end
        checkOutput("refAddr",    capAddr, 0);
        checkOutput("refLen",     capLen, 0);
        checkOutput("refNoGrant", grantNz - bNz, 0);
        n = 0;
        while (cyc < relCyc + 1620 && n < 1000) begin
            tick();
            n++;
        end
        applyStimulus(0, CmdWrite, 21'h00300, 8'd0, 4'h3, 32'hDEAD_BEEF);
        waitDone(0, 60, "colDone");
        checkOutput("colRefCount", refCnt - bRef, 4);
        if (refCnt - bRef >= 4 && bRef + 3 < 8) begin
            checkOutput("colRefCyc", refCyc[bRef + 3] - relCyc, 1621);
            checkOutput("colWrAfter", nonRefCmdCyc - refCyc[bRef + 3], 6);
        end
        checkOutput("colBeats", wrCnt - bWr, 1);

        // Controller not initialised: nothing issued, refresh counter frozen
        resetDut(1'b0, relCyc);
        bCmd = cmdEnCnt; bNz = grantNz; bRef = refCnt;
        applyStimulus(0, CmdWrite, 21'h00040, 8'd0, 4'h0, 32'h0);
        applyStimulus(1, CmdRead,  21'h00080, 8'd0, 4'h0, 32'h0);
        repeat (60) tick();
        checkOutput("initCmdEn", cmdEnCnt - bCmd, 0);
        checkOutput("initGrant", grantNz - bNz, 0);
        checkOutput("initGrantNow", bus.grant, 0);
        bus.req            = '0;
        bus.sdrc_init_done = 1'b1;
        b = cyc;
        n = 0;
        while (cmdEnCnt == bCmd && n < 500) begin
            tick();
            n++;
        end
        checkOutput("initRefCount", refCnt - bRef, 1);
        checkOutput("initRefCmd",   capCmd, CmdRefresh);
        if (refCnt > bRef && refCnt - 1 < 8) begin
            checkOutput("initRefCyc", refCyc[refCnt - 1] - b, 406);
        end

        // Reset in the middle of a 256-beat write
        resetDut(1'b1, relCyc);
        bWr = wrCnt; bD0 = done0Cnt;
        applyStimulus(0, CmdWrite, 21'h00200, 8'd255, 4'h0, 32'h5A5A_5A5A);
        n = 0;
        while (wrCnt - bWr < 10 && n < 50) begin
            tick();
            n++;
        end
        checkOutput("midBeats", (wrCnt - bWr >= 10) ? 1 : 0, 1);
        rst = 1'b1;
        #1;
        checkOutput("midGrant",  bus.grant, 0);
        checkOutput("midWrNext", bus.wr_next, 0);
        checkOutput("midCmdEn",  bus.sdrc_cmd_en, 0);
        checkOutput("midDone",   bus.done, 0);
        checkOutput("midWdata",  bus.sdrc_wdata, 0);
        repeat (2) tick();
        bus.req_len[7:0] = 8'd1;
        bWr = wrCnt;
        rst = 1'b0;
        waitDone(0, 60, "postDone");
        checkOutput("postDoneOnce", done0Cnt - bD0, 1);
        checkOutput("postBeats",    wrCnt - bWr, 2);
        checkOutput("postLen",      capLen, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
